// File: rtl/led_pwm_ctrl_if.sv
// Signal bundle between the LED register block (master) and the PWM/blink driver (slave).
interface led_pwm_ctrl_if;
  logic [7:0] LED_IN;
  logic [7:0] DUTY;
  logic [7:0] BLINK_EN;
  logic [7:0] LED_OUT;
  logic       PERIOD_STROBE;

  modport master (
    output LED_IN,
    output DUTY,
    output BLINK_EN,
    input  LED_OUT,
    input  PERIOD_STROBE
  );

  modport slave (
    input  LED_IN,
    input  DUTY,
    input  BLINK_EN,
    output LED_OUT,
    output PERIOD_STROBE
  );
endinterface

// File: rtl/led_pwm_ctrl.sv
// LED dimmer and blinker: 8-bit PWM with prescaled tick, period-aligned shadow registers
// and a slow blink phase. All outputs are registered.
module led_pwm_ctrl #(
  parameter int unsigned PRESCALE      = 16,
  parameter int unsigned BLINK_PERIODS = 64
) (
  input logic            PCLK,
  input logic            PRESETn,
  led_pwm_ctrl_if.slave  bus
);

  localparam logic [15:0] PreMax   = 16'(PRESCALE - 1);
  localparam logic [15:0] BlinkMax = 16'(BLINK_PERIODS - 1);

  logic [15:0] pre_cnt_q, pre_cnt_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic        blink_phase_q, blink_phase_d;
  logic        first_load_q;
  logic [7:0]  led_sh_q, led_sh_d;
  logic [7:0]  duty_sh_q, duty_sh_d;
  logic [7:0]  blink_sh_q, blink_sh_d;
  logic [7:0]  led_out_q, led_out_d;
  logic        strobe_q;

  logic tick;
  logic pstart;
  logic load;
  logic pwm_on;

  assign tick   = (pre_cnt_q == PreMax);
  assign pstart = tick & (pwm_cnt_q == 8'hFF);
  // Shadows only move at period boundaries so a period is never cut mid-way.
  assign load   = pstart | first_load_q;
  assign pwm_on = (duty_sh_q == 8'hFF) | (pwm_cnt_q < duty_sh_q);

  always_comb begin
    pre_cnt_d     = tick ? 16'd0 : pre_cnt_q + 16'd1;
    pwm_cnt_d     = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    led_sh_d      = led_sh_q;
    duty_sh_d     = duty_sh_q;
    blink_sh_d    = blink_sh_q;

    if (pstart) begin
      if (blink_cnt_q == BlinkMax) begin
        blink_cnt_d   = 16'd0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 16'd1;
      end
    end

    if (load) begin
      led_sh_d   = bus.LED_IN;
      duty_sh_d  = bus.DUTY;
      blink_sh_d = bus.BLINK_EN;
    end

    led_out_d = led_sh_q & {8{pwm_on}} & (~blink_sh_q | {8{blink_phase_q}});
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pre_cnt_q     <= 16'd0;
      pwm_cnt_q     <= 8'd0;
      blink_cnt_q   <= 16'd0;
      blink_phase_q <= 1'b1;
      first_load_q  <= 1'b1;
      led_sh_q      <= 8'd0;
      duty_sh_q     <= 8'd0;
      blink_sh_q    <= 8'd0;
      led_out_q     <= 8'd0;
      strobe_q      <= 1'b0;
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      first_load_q  <= 1'b0;
      led_sh_q      <= led_sh_d;
      duty_sh_q     <= duty_sh_d;
      blink_sh_q    <= blink_sh_d;
      led_out_q     <= led_out_d;
      strobe_q      <= pstart;
    end
  end

  assign bus.LED_OUT       = led_out_q;
  assign bus.PERIOD_STROBE = strobe_q;

endmodule
